// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, access
// size encodings and the request legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

  // Misaligned half/word accesses and the reserved size code are rejected.
  function automatic logic req_bad(input logic [1:0] size, input logic [LANE_W-1:0] lane);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lane[0];
      SIZE_W:  return lane != '0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extraction with sign/zero extension and
// read-modify-write merge of a byte or half into the old memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [LANE_W-1:0] lane,
  input  logic [31:0]       rd_word,
  input  logic [31:0]       old_word,
  input  logic [31:0]       wdata,
  output logic [31:0]       load_data,
  output logic [31:0]       store_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  always_comb begin
    shamt      = {lane, 3'b000};
    shifted    = rd_word >> shamt;
    load_data  = shifted;
    lane_mask  = '0;
    lane_data  = '0;
    store_word = wdata;
    case (size)
      SIZE_B: begin
        load_data  = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask  = 32'h0000_00FF << shamt;
        lane_data  = {24'h0, wdata[7:0]} << shamt;
        store_word = (old_word & ~lane_mask) | lane_data;
      end
      SIZE_H: begin
        load_data  = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask  = 32'h0000_FFFF << shamt;
        lane_data  = {16'h0, wdata[15:0]} << shamt;
        store_word = (old_word & ~lane_mask) | lane_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit for a word-indexed, async-read,
// sync-write data memory; sub-word stores use a read-modify-write cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  state_t          state, state_next;
  logic            we_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     old_word_q;
  logic [31:0]     load_data;
  logic [31:0]     store_word;
  logic            accept;
  logic            bad;
  logic            sub_word_store;

  assign req_ready      = (state == IDLE);
  assign accept         = req_valid && req_ready;
  assign bad            = req_bad(req_size, req_addr[LANE_W-1:0]);
  assign sub_word_store = we_q && (size_q != SIZE_W);

  lsu_lane_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .lane        (addr_q[LANE_W-1:0]),
    .rd_word     (mem_rd),
    .old_word    (old_word_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bad ? RESP : ACCESS;
      ACCESS:  state_next = sub_word_store ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory port: address is held for the whole access, write strobe is
  // killed combinationally by reset so an in-flight merge never lands.
  always_comb begin
    mem_addr = (state == IDLE) ? '0 : {2'b00, addr_q[31:2]};
    mem_we   = 1'b0;
    mem_wd   = '0;
    if (state == ACCESS && we_q && !sub_word_store) begin
      mem_we = 1'b1;
      mem_wd = wdata_q;
    end else if (state == WRITE) begin
      mem_we = 1'b1;
      mem_wd = store_word;
    end
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      old_word_q <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state     <= state_next;
      rsp_valid <= (state_next == RESP);
      case (state)
        IDLE: if (accept) begin
          we_q       <= req_we;
          size_q     <= req_size;
          unsigned_q <= req_unsigned;
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          rsp_err    <= bad;
          rsp_rdata  <= '0;
        end
        ACCESS: begin
          if (!we_q) rsp_rdata <= load_data;
          else if (sub_word_store) old_word_q <= mem_rd;
        end
        default: ;
      endcase
    end
  end

endmodule
